// File: rtl/mem_access_unit_if.sv
// Request/grant/response data-memory bus between the MEM-stage access unit
// (master) and the data memory (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the data bus with byte enables and
// replicated store data, right-aligns load data for the sign/zero extender.
module mem_access_unit (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  input  logic                      op_we,
  input  logic [2:0]                op_funct3,
  input  logic [31:0]               op_addr,
  input  logic [31:0]               op_wdata,
  output logic                      stall,
  output logic                      done,
  output logic                      mem_err,
  output logic [31:0]               load_data,
  output logic [2:0]                load_funct3,
  mem_access_unit_if.master         bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, nstate;
  logic        we_q, err_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic [1:0]  off, size;
  logic        op_err;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign off  = op_addr[1:0];
  assign size = op_funct3[1:0];

  // size 11 and unsigned-word 110 are illegal for loads; stores have no unsigned forms
  assign op_err = (size == 2'b11) || (op_funct3 == 3'b110) || (op_we && op_funct3[2]) ||
                  ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = op_wdata;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (op_valid) nstate = op_err ? DONE : REQ;
      REQ:     if (bus.bus_gnt) nstate = we_q ? DONE : RESP;
      RESP:    if (bus.bus_rvalid) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      load_data   <= 32'h0;
      load_funct3 <= 3'b000;
    end else begin
      if (state == IDLE && op_valid) begin
        we_q    <= op_we;
        err_q   <= op_err;
        off_q   <= off;
        f3_q    <= op_funct3;
        addr_q  <= {op_addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
      end
      if (state == RESP && bus.bus_rvalid) begin
        load_data   <= bus.bus_rdata >> {off_q, 3'b000};
        load_funct3 <= f3_q;
      end
    end
  end

  // Bus fields are only latched in IDLE, so they stay stable across grant stalls
  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  assign done    = (state == DONE);
  assign mem_err = done && err_q;
  assign stall   = op_valid && (state != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reset, grant stalls, store/load
// alignment, misaligned and illegal-funct3 errors.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_we;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        stall, done, mem_err;
  logic [31:0] load_data;
  logic [2:0]  load_funct3;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_access_unit_if bif();

  mem_access_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_we(op_we),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
    .stall(stall), .done(done), .mem_err(mem_err),
    .load_data(load_data), .load_funct3(load_funct3), .bus(bif)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    op_valid  = 1'b1;
    op_we     = we;
    op_funct3 = f3;
    op_addr   = a;
    op_wdata  = wd;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_funct3 = 3'b0;
    op_addr = 32'h0; op_wdata = 32'h0;
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = 32'h0;
    tick; tick;
    #1;
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_req", {31'b0, bif.bus_req}, 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_addr", bif.bus_addr, 32'h0);

    // reset while a load waits for grant
    rst = 1'b0;
    tick;
    set_op(1'b0, 3'b010, 32'h0000_0104, 32'h0);
    tick;
    #1;
    chk("mid_req_active", {31'b0, bif.bus_req}, 32'd1);
    rst = 1'b1; op_valid = 1'b0;
    tick;
    #1;
    chk("mid_rst_req", {31'b0, bif.bus_req}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_addr", bif.bus_addr, 32'h0);
    chk("mid_rst_be", {28'b0, bif.bus_be}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    tick;

    // lbu @0x1003, grant held off two cycles
    set_op(1'b0, 3'b100, 32'h0000_1003, 32'h0);   // cycle 1
    #1;
    chk("lbu_c1_stall", {31'b0, stall}, 32'd1);
    tick;                                           // cycle 2
    chk("lbu_c2_req", {31'b0, bif.bus_req}, 32'd1);
    chk("lbu_addr", bif.bus_addr, 32'h0000_1000);
    chk("lbu_be", {28'b0, bif.bus_be}, 32'h8);
    chk("lbu_c2_stall", {31'b0, stall}, 32'd1);
    tick;                                           // cycle 3
    chk("lbu_c3_req", {31'b0, bif.bus_req}, 32'd1);
    chk("lbu_c3_addr_held", bif.bus_addr, 32'h0000_1000);
    tick;                                           // cycle 4
    bif.bus_gnt = 1'b1;
    #1;
    chk("lbu_c4_req", {31'b0, bif.bus_req}, 32'd1);
    tick;                                           // cycle 5
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hA1B2_C3D4;
    #1;
    chk("lbu_c5_req", {31'b0, bif.bus_req}, 32'd0);
    chk("lbu_c5_done", {31'b0, done}, 32'd0);
    chk("lbu_c5_stall", {31'b0, stall}, 32'd1);
    tick;                                           // cycle 6
    bif.bus_rvalid = 1'b0;
    chk("lbu_c6_done", {31'b0, done}, 32'd1);
    chk("lbu_c6_stall", {31'b0, stall}, 32'd0);
    chk("lbu_c6_err", {31'b0, mem_err}, 32'd0);
    chk("lbu_data", load_data, 32'h0000_00A1);
    chk("lbu_f3", {29'b0, load_funct3}, 32'd4);
    op_valid = 1'b0;
    tick;
    chk("lbu_done_pulse", {31'b0, done}, 32'd0);

    // sh @0x2002, immediate grant
    set_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678);
    bif.bus_gnt = 1'b1;
    tick;                                           // cycle 2
    chk("sh_req", {31'b0, bif.bus_req}, 32'd1);
    chk("sh_we", {31'b0, bif.bus_we}, 32'd1);
    chk("sh_be", {28'b0, bif.bus_be}, 32'hC);
    chk("sh_wdata", bif.bus_wdata, 32'h5678_5678);
    chk("sh_addr", bif.bus_addr, 32'h0000_2000);
    tick;                                           // cycle 3
    chk("sh_done", {31'b0, done}, 32'd1);
    chk("sh_err", {31'b0, mem_err}, 32'd0);
    chk("sh_keeps_load", load_data, 32'h0000_00A1);
    op_valid = 1'b0;
    tick;

    // lw @0x3000, data one cycle after grant
    set_op(1'b0, 3'b010, 32'h0000_3000, 32'h0);
    tick;                                           // cycle 2 (granted)
    chk("lw_be", {28'b0, bif.bus_be}, 32'hF);
    chk("lw_we", {31'b0, bif.bus_we}, 32'd0);
    tick;                                           // cycle 3
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_c3_done", {31'b0, done}, 32'd0);
    tick;                                           // cycle 4
    bif.bus_rvalid = 1'b0;
    chk("lw_done", {31'b0, done}, 32'd1);
    chk("lw_data", load_data, 32'hDEAD_BEEF);
    chk("lw_f3", {29'b0, load_funct3}, 32'd2);

    // misaligned lw presented back-to-back in cycle 5
    tick;
    set_op(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    #1;
    chk("mis_lw_c1_stall", {31'b0, stall}, 32'd1);
    chk("mis_lw_c1_req", {31'b0, bif.bus_req}, 32'd0);
    tick;
    chk("mis_lw_done", {31'b0, done}, 32'd1);
    chk("mis_lw_err", {31'b0, mem_err}, 32'd1);
    chk("mis_lw_req", {31'b0, bif.bus_req}, 32'd0);
    chk("mis_lw_data", load_data, 32'hDEAD_BEEF);

    tick;
    set_op(1'b0, 3'b001, 32'h0000_3001, 32'h0);     // misaligned lh
    #1;
    chk("mis_lh_c1_err", {31'b0, mem_err}, 32'd0);
    tick;
    chk("mis_lh_err", {31'b0, mem_err}, 32'd1);
    chk("mis_lh_req", {31'b0, bif.bus_req}, 32'd0);
    chk("mis_lh_f3", {29'b0, load_funct3}, 32'd2);

    tick;
    set_op(1'b0, 3'b011, 32'h0000_3000, 32'h0);     // illegal load funct3
    tick;
    chk("ill_ld_err", {31'b0, mem_err}, 32'd1);
    chk("ill_ld_req", {31'b0, bif.bus_req}, 32'd0);

    tick;
    set_op(1'b1, 3'b100, 32'h0000_3000, 32'h0);     // illegal store funct3
    tick;
    chk("ill_st_err", {31'b0, mem_err}, 32'd1);
    chk("ill_st_done", {31'b0, done}, 32'd1);
    chk("ill_st_data", load_data, 32'hDEAD_BEEF);

    // sb @0x4001 after errors
    tick;
    set_op(1'b1, 3'b000, 32'h0000_4001, 32'h0000_00AB);
    bif.bus_gnt = 1'b1;
    tick;
    chk("sb_req", {31'b0, bif.bus_req}, 32'd1);
    chk("sb_be", {28'b0, bif.bus_be}, 32'h2);
    chk("sb_wdata", bif.bus_wdata, 32'hABAB_ABAB);
    tick;
    chk("sb_done", {31'b0, done}, 32'd1);
    chk("sb_err", {31'b0, mem_err}, 32'd0);
    op_valid = 1'b0; bif.bus_gnt = 1'b0;
    tick;
    chk("final_idle_stall", {31'b0, stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit in the MEM stage. It sits directly upstream of the load sign/zero-extension stage. It accepts one memory operation per pipeline slot and drives a request/grant/response data-memory bus, generating byte enables and lane-replicated store data. For loads, it right-aligns the returned word so the addressed byte or halfword lands at bit 0, then hands it to the extender with the latched `funct3`. It stalls the pipeline until the operation completes.

## Interface
Parameters: none (XLEN fixed at 32).

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: memory op present in MEM; held stable while `stall`=1.
- `op_we` in 1: 1 = store, 0 = load.
- `op_funct3` in 3: RISC-V load/store `funct3`.
- `op_addr` in 32: effective byte address.
- `op_wdata` in 32: store data (rs2).
- `stall` out 1: hold the pipeline.
- `done` out 1: one-cycle completion pulse.
- `mem_err` out 1: valid with `done`; misaligned access or illegal `funct3`.
- `load_data` out 32: right-aligned raw load word, fed to the extender `data` input.
- `load_funct3` out 3: latched `funct3`, fed to the extender.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out 32: word address (`{addr[31:2],2'b00}`).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE.** On `op_valid`, latch `we`, `funct3`, byte offset `off=addr[1:0]`, `bus_addr`, `bus_be`, and `bus_wdata`.
  - Error → DONE with the error flag set.
  - No error → REQ.
- **REQ.** `bus_req`=1.
  - `bus_gnt`=1 and store → DONE.
  - `bus_gnt`=1 and load → RESP.
  - `bus_gnt`=0 → stay in REQ; all bus outputs are held stable.
- **RESP.** Wait for `bus_rvalid`. On `bus_rvalid`, set `load_data = bus_rdata >> (8*off)` (zero-fill from the top) and go to DONE.
- **DONE.** `done`=1, `stall`=0. Go to IDLE.
- Error conditions:
  - Halfword with `off[0]`=1.
  - Word with `off`≠0.
  - Load `funct3` ∈ {011,110,111}.
  - Store `funct3` ∉ {000,001,010}.
  - On error: no bus request is issued, `mem_err`=1 in DONE, and `load_data` is unchanged.
- Byte enables: byte `0001<<off`; half `0011<<off`; word `1111`.
- Store data: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word `wdata`.
- `stall = op_valid & (state != DONE)`. This is combinational, so the first cycle of an op already stalls.
- `load_data` and `load_funct3` hold their values until the next load completes. Stores do not modify `load_data`.

## Timing
- Reset: state=IDLE. All registered outputs are 0: `done`, `mem_err`, `load_data`, `load_funct3`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`.
- Reset mid-operation: the FSM returns to IDLE at that edge and `bus_req` drops. An outstanding response is ignored.
- Store latency with `bus_gnt` in the first REQ cycle is 3 cycles (IDLE, REQ, DONE). Each cycle without grant adds 1.
- Load latency with `bus_gnt` immediate and `bus_rvalid` one cycle later is 4 cycles. Each wait cycle adds 1.
- Error latency is 2 cycles (IDLE, DONE).
- `bus_rvalid` is sampled only in RESP. The bus must not return data in the grant cycle.
- Back-to-back ops: the op presented in the cycle after DONE is a new op and starts in IDLE. This gives a 1-cycle gap.
- `done` and `mem_err` are high for exactly one cycle per op.

## Test plan
- **Reset mid-REQ.** Load waiting for grant, assert `rst` → next cycle state IDLE, `bus_req`=0, `done`=0, all outputs 0.
- **Load byte, grant stalled.**
  - Stimulus: lbu at addr 0x1003; `bus_gnt` low 2 cycles then high; `bus_rdata`=0xA1B2C3D4.
  - Response: `bus_addr`=0x1000, `bus_be`=1000, `load_data`=0x000000A1, `load_funct3`=100; `done` on cycle 6, `stall` high cycles 1–5.
- **Store half.**
  - Stimulus: sh at addr 0x2002, `op_wdata`=0x12345678, immediate grant.
  - Response: `bus_we`=1, `bus_be`=1100, `bus_wdata`=0x56785678; `done` on cycle 3.
- **Load word.**
  - Stimulus: lw at addr 0x3000; `bus_rdata`=0xDEADBEEF one cycle after grant.
  - Response: `load_data`=0xDEADBEEF; `done` on cycle 4; next op accepted in cycle 5.
- **Misaligned.** lw at 0x3002 or lh at 0x3001 → `bus_req` never asserted; `mem_err`=1 with `done` on cycle 2; `load_data` unchanged.
- **Illegal funct3.** Load with `funct3`=011, and store with `funct3`=100 → `mem_err`=1, no bus activity. A following valid sb at 0x4001 gives `bus_be`=0010.
